// File: rtl/nibble_add_sequencer.sv
// Multi-nibble adder that reuses one 4-bit ripple adder, one nibble per clock.
// Contains the shared ripple_adder and the sequencer top.

module ripple_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[4];
endmodule

// state | meaning
// IDLE  | waiting for start, result outputs hold last value
// RUN   | one nibble summed per clock, start ignored
// DONE  | one-cycle result pulse, start accepted back-to-back
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 overflow
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [W-1:0]      r_a, r_b, r_work;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;

  logic [3:0]        w_nib_sum;
  logic              w_nib_cout;
  logic              w_accept;
  logic              w_last;
  logic [W-1:0]      w_work_nxt;

  ripple_adder u_add (
    .i_a    (r_a[{r_idx, 2'b00} +: 4]),
    .i_b    (r_b[{r_idx, 2'b00} +: 4]),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  assign w_last = (r_idx == IDXW'(NIBBLES - 1));

  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[{r_idx, 2'b00} +: 4] = w_nib_sum;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_work  <= '0;
        r_idx   <= '0;
      end else if (r_state == S_RUN) begin
        r_work  <= w_work_nxt;
        r_carry <= w_nib_cout;
        r_idx   <= r_idx + 1'b1;
        // Result outputs only move on the final nibble so they never show partial sums.
        if (w_last) begin
          sum      <= w_work_nxt;
          cout     <= w_nib_cout;
          overflow <= (r_a[W-1] == r_b[W-1]) && (w_work_nxt[W-1] != r_a[W-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer (NIBBLES=4) with hand-computed results.
module tb_nibble_add_sequencer;
  logic        clk, rst, start, cin;
  logic [15:0] a, b;
  logic        ready, busy, done, cout, overflow;
  logic [15:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_add_sequencer #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts. Returns at the first RUN negedge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
  endtask

  task automatic check_busy(input int n, input logic [15:0] ps, input logic pc, input logic po);
    for (int i = 0; i < n; i++) begin
      chk("busy", busy, 1);
      chk("busy_ready", ready, 0);
      chk("busy_done", done, 0);
      chk("busy_sum_hold", sum, ps);
      chk("busy_cout_hold", cout, pc);
      chk("busy_ovf_hold", overflow, po);
      @(negedge clk);
    end
  endtask

  task automatic check_done(input logic [15:0] es, input logic ec, input logic eo);
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_ready", ready, 1);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("overflow", overflow, eo);
  endtask

  task automatic check_idle(input logic [15:0] es, input logic ec, input logic eo);
    chk("idle_ready", ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_sum", sum, es);
    chk("idle_cout", cout, ec);
    chk("idle_ovf", overflow, eo);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check_idle(16'h0000, 0, 0);

    // release reset and request on the very first edge
    rst = 1'b0;
    start_op(16'h00FF, 16'h0001, 1'b0);
    check_busy(4, 16'h0000, 0, 0);
    check_done(16'h0100, 0, 0);
    @(negedge clk);
    check_idle(16'h0100, 0, 0);

    start_op(16'hFFFF, 16'h0000, 1'b1);
    check_busy(4, 16'h0100, 0, 0);
    check_done(16'h0000, 1, 0);
    @(negedge clk);

    start_op(16'h7FFF, 16'h0001, 1'b0);
    check_busy(4, 16'h0000, 1, 0);
    check_done(16'h8000, 0, 1);
    @(negedge clk);

    // start during RUN is ignored, then back-to-back from DONE
    start_op(16'h1234, 16'h4321, 1'b0);
    check_busy(1, 16'h8000, 0, 1);
    start = 1'b1; a = 16'h1111; b = 16'h1111;
    check_busy(1, 16'h8000, 0, 1);
    start = 1'b0;
    check_busy(2, 16'h8000, 0, 1);
    check_done(16'h5555, 0, 0);
    start_op(16'h0002, 16'h0003, 1'b0);
    check_busy(4, 16'h5555, 0, 0);
    check_done(16'h0005, 0, 0);
    @(negedge clk);

    // reset two cycles into an operation
    start_op(16'hAAAA, 16'h5555, 1'b0);
    check_busy(2, 16'h0005, 0, 0);
    rst = 1'b1;
    #1;
    check_idle(16'h0000, 0, 0);
    @(negedge clk);
    check_idle(16'h0000, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check_idle(16'h0000, 0, 0);

    start_op(16'h0F0F, 16'h0101, 1'b1);
    check_busy(4, 16'h0000, 0, 0);
    check_done(16'h1011, 0, 0);
    @(negedge clk);

    start_op(16'h8000, 16'h8000, 1'b0);
    check_busy(4, 16'h1011, 0, 0);
    check_done(16'h0000, 1, 1);
    @(negedge clk);
    check_idle(16'h0000, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
